// File: rtl/sram_rmw_ctrl.sv
// sram_rmw_ctrl
//   Request-side controller for the 512x32 single-port SRAM wrapper. Accepts
//   word reads and byte-strobed writes on a valid/ready request channel and
//   returns exactly one response per request on a valid/ready response channel.
//   Full-word writes go straight to the SRAM. Partial writes are done as
//   read-modify-write because the wrapper only writes whole words.
//
// Ports
//   clk, reset_n                       clock (rising edge), async active-low reset
//   req_valid/req_ready                request handshake
//   req_addr/req_we/req_wstrb/req_wdata  request payload
//   rsp_valid/rsp_ready/rsp_rdata      response handshake + data (read data, or
//                                      the word as stored after a write)
//   mem_en/mem_addr/mem_wen/mem_wdata  SRAM access port (one cycle per access)
//   mem_rdata                          SRAM read word, valid the cycle after a read
module sram_rmw_ctrl #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [3:0]            req_wstrb,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR} state_t;

  // Request held across the read / merge / write sequence.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  rmw;   // 1 = partial write, 0 = plain read
  } hold_t;

  state_t      state, state_nxt;
  hold_t       hold;
  logic [31:0] merged_d, merged_q;
  logic        accept, is_full, is_rmw;

  // reset_n is folded in so nothing is accepted while reset is held.
  assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready) && reset_n;
  assign accept    = req_valid && req_ready;
  assign is_full   = req_we && (req_wstrb == 4'hF);
  assign is_rmw    = req_we && (req_wstrb != 4'h0) && !is_full;

  // Byte merge of held write data over the word just read back.
  for (genvar b = 0; b < 4; b++) begin : g_merge
    assign merged_d[8*b +: 8] = hold.wstrb[b] ? hold.wdata[8*b +: 8] : mem_rdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = hold.addr;
    mem_wdata = merged_q;
    case (state)
      IDLE: begin
        if (accept) begin
          // Access issued in the accept cycle itself; a full write completes here.
          mem_en    = 1'b1;
          mem_addr  = req_addr;
          mem_wen   = is_full;
          mem_wdata = req_wdata;
          if (!is_full) state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = hold.rmw ? RMW_WR : IDLE;
      RMW_WR: begin
        mem_en    = 1'b1;
        mem_wen   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold     <= '0;
      merged_q <= '0;
    end else begin
      if (state == IDLE && accept && !is_full) begin
        hold.addr  <= req_addr;
        hold.wdata <= req_wdata;
        hold.wstrb <= req_wstrb;
        hold.rmw   <= is_rmw;
      end
      if (state == RD_WAIT) merged_q <= merged_d;
    end
  end

  // Response slot: a new load takes priority over the handshake clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (state == IDLE && accept && is_full) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= req_wdata;
    end else if (state == RD_WAIT && !hold.rmw) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= mem_rdata;
    end else if (state == RMW_WR) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= merged_q;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sram_rmw_ctrl.md
# sram_rmw_ctrl

Request-side controller for the 512x32 single-port SRAM wrapper; it drives that wrapper's `en`/`addr`/`wen`/`wdata` port and consumes its `rdata`. It accepts word reads and byte-strobed writes over a valid/ready request channel. Partial writes are implemented as read-modify-write, because the SRAM wrapper only supports whole-word writes. Every request returns exactly one response on a valid/ready response channel. The block sits between the core's load/store bus adapter and the SRAM wrapper.

## Interface

Parameters:
- `ADDR_WIDTH`, 9: word address width; must match the SRAM depth of 512 words.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller accepts a request this cycle.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_we`  in  1  1 = write, 0 = read.
- `req_wstrb`  in  4  byte strobes; bit i enables `req_wdata[8i+7:8i]`.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  read data, or the word as stored after a write.
- `mem_en`  out  1  SRAM access enable, one cycle per access.
- `mem_addr`  out  ADDR_WIDTH  SRAM address.
- `mem_wen`  out  1  SRAM write enable, meaningful only with `mem_en`.
- `mem_wdata`  out  32  SRAM write word.
- `mem_rdata`  in  32  SRAM read word, valid the cycle after a read access.

## Operation

- States: IDLE, RD_WAIT, RMW_WR.
- `req_ready` = (state == IDLE) && (!rsp_valid || rsp_ready) && reset_n.
- Request kinds are classified at acceptance:
  - read: `req_we` = 0, or `req_we` = 1 with `req_wstrb` = 0 (no write is issued).
  - full write: `req_we` = 1, `req_wstrb` = 4'hF.
  - partial write: any other nonzero strobe.
- IDLE, on accept:
  - `mem_en` = 1 and `mem_addr` = `req_addr` combinationally in the accept cycle.
  - Full write: `mem_wen` = 1, `mem_wdata` = `req_wdata`. Load `rsp_rdata` = `req_wdata` and set `rsp_valid`. Stay in IDLE.
  - Read or partial write: `mem_wen` = 0. Latch addr, wdata, wstrb and kind. Go to RD_WAIT.
- RD_WAIT:
  - Read: `rsp_rdata` <= `mem_rdata`, set `rsp_valid`, go to IDLE.
  - Partial write: compute merged = per byte (wstrb[i] ? wdata byte : `mem_rdata` byte). Go to RMW_WR with merged registered.
- RMW_WR: `mem_en` = 1, `mem_wen` = 1, `mem_addr` = latched addr, `mem_wdata` = merged. Set `rsp_valid` with `rsp_rdata` = merged. Go to IDLE.
- Outside access cycles: `mem_en` = 0, `mem_wen` = 0. `mem_addr`/`mem_wdata` are don't-care.
- Response channel:
  - `rsp_valid` clears on `rsp_valid && rsp_ready` unless a new response loads in the same cycle; the load wins.
  - `rsp_rdata` is stable while `rsp_valid && !rsp_ready`.
- Requests are strictly in order with no overlap, so read-after-write to the same address needs no forwarding.

## Timing

- Reset (asynchronous assert):
  - state = IDLE.
  - `rsp_valid` = 0, `rsp_rdata` = 0.
  - `req_ready` = 0, `mem_en` = 0, `mem_wen` = 0 immediately.
- Reset release: `req_ready` may rise on the first cycle after `reset_n` is high.
- Latency, with the accept cycle = cycle 0:
  - Full write: SRAM write in cycle 0, `rsp_valid` in cycle 1.
  - Read: SRAM read in cycle 0, data sampled in cycle 1, `rsp_valid` in cycle 2.
  - Partial write: read in cycle 0, merge in cycle 1, write in cycle 2, `rsp_valid` in cycle 3.
- Throughput, with `rsp_ready` held 1:
  - full writes: 1 per cycle.
  - reads: 1 per 2 cycles.
  - partial writes: 1 per 3 cycles.
- Backpressure: while `rsp_valid && !rsp_ready`, `req_ready` = 0. No SRAM access occurs and state holds IDLE.
- Reset mid-RMW:
  - Asserted in RD_WAIT: no write is issued and the SRAM word is unchanged.
  - Asserted in RMW_WR before the clock edge: the write may or may not complete. Software must not rely on the result.
- `req_*` is sampled only in the accept cycle. Changes while `req_ready` = 0 have no effect.

## Test plan

- Reset with `req_valid` = 1: `req_ready`, `mem_en` and `rsp_valid` stay 0 throughout. After release, the first request is accepted in the cycle following deassertion.
- Full write addr 0x1A5 data 0xDEADBEEF, then read 0x1A5:
  - write: `mem_en` = `mem_wen` = 1 in cycle 0, `rsp_valid` cycle 1 with 0xDEADBEEF.
  - read: `rsp_valid` 2 cycles after accept with 0xDEADBEEF.
- Preload 0x11223344 at addr 7, write wstrb 4'b0101 data 0xAABBCCDD:
  - `mem_en` sequence is read, idle, write.
  - `mem_wdata` = 0x11BB33DD, `rsp_rdata` = 0x11BB33DD in cycle 3.
  - Readback returns 0x11BB33DD.
- Write with wstrb 0 to addr 3 holding 0x5A5A5A5A: `mem_wen` never asserts, and the response returns 0x5A5A5A5A after 2 cycles.
- Hold `rsp_ready` = 0 for 5 cycles after a read response:
  - `rsp_rdata` stays stable, `req_ready` = 0, no `mem_en` pulses.
  - On `rsp_ready` = 1 with `req_valid` = 1, the next request is accepted in that same cycle.
- Assert `reset_n` low during RD_WAIT of a partial write to addr 9 holding 0x01020304: no SRAM write occurs, and a later read of addr 9 returns 0x01020304.
